marker_sequence_scheduler: RTL and testbench

- HCLK-domain controller that sequences the DTC marker simulator.
- Firmware writes a small table of marker commands (type, sequence number, gap). On `run`, the block replays the table one or more times.
- For each entry it drives `marker_type`/`seq_num` and a bounded `start` pulse, then holds off until the gap expires.
- Sits between the AHB/APB register bank and the simulator's `start`/`MARKER_TYPE`/`SEQ_NUM` inputs.

---
 rtl/marker_sequence_scheduler.sv | 145 ++++++++++++++
 tb/tb_marker_sequence_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/marker_sequence_scheduler.sv
// Replays a firmware-written table of marker commands into the DTC marker simulator (start/type/seq).
// Define MARKER_SCHED_LFSR_EN to take seq_num from a 4-bit LFSR for marker types 3, 11 and 14.
module marker_sequence_scheduler #(
  parameter int DEPTH      = 8,
  parameter int START_HOLD = 2,
  parameter int MIN_GAP    = 32
) (
  input  logic                     HCLK,
  input  logic                     HRESETN,
  input  logic                     tbl_wr_en,
  input  logic [$clog2(DEPTH)-1:0] tbl_wr_addr,
  input  logic [15:0]              tbl_wr_data,
  input  logic [$clog2(DEPTH):0]   num_entries,
  input  logic [7:0]               loop_count,
  input  logic                     run,
  input  logic                     abort,
  output logic                     start,
  output logic [3:0]               marker_type,
  output logic [3:0]               seq_num,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [$clog2(DEPTH)-1:0] entry_idx,
  output logic [31:0]              issued_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W     = (AW+1)'(1);
  localparam logic [8:0]  MIN_GAP_W = 9'(MIN_GAP);
  localparam logic [8:0]  HOLD_LAST = 9'(START_HOLD - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ASSERT, S_GAP, S_DONE} state_t;
  state_t state, next_state;

  logic [15:0]   tbl [DEPTH];
  logic [15:0]   entry;
  logic          run_q, run_rise;
  logic [AW:0]   n_reg, n_in;
  logic [7:0]    l_reg, pass_q, gap_reg;
  logic [AW-1:0] ptr;
  logic [8:0]    cnt, gap_len;
  logic [3:0]    seq_src;
  logic          hold_end, gap_end, last_entry, last_pass, issue;

  always_ff @(posedge HCLK)
    if (tbl_wr_en && !busy) tbl[tbl_wr_addr] <= tbl_wr_data;

  assign entry      = tbl[ptr];
  assign run_rise   = run & ~run_q;
  assign n_in       = (num_entries > DEPTH_W) ? DEPTH_W : num_entries;
  assign gap_len    = ({1'b0, gap_reg} > MIN_GAP_W) ? {1'b0, gap_reg} : MIN_GAP_W;
  assign hold_end   = (cnt == HOLD_LAST);
  assign gap_end    = (cnt == gap_len - 9'd1);
  assign last_entry = (({1'b0, ptr} + ONE_W) >= n_reg);
  assign last_pass  = (l_reg != 8'd0) && ((pass_q + 8'd1) == l_reg);
  assign issue      = (state == S_LOAD) && !abort;

`ifdef MARKER_SCHED_LFSR_EN
  logic [3:0] lfsr_q, lfsr_nxt;
  // x^4+x^3+1 Fibonacci; the advanced value is the one handed to the simulator
  assign lfsr_nxt = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  always_ff @(posedge HCLK or negedge HRESETN)
    if (!HRESETN)   lfsr_q <= 4'b0001;
    else if (issue) lfsr_q <= lfsr_nxt;
  assign seq_src = (entry[15:12] == 4'd3 || entry[15:12] == 4'd11 || entry[15:12] == 4'd14)
                   ? lfsr_nxt : entry[11:8];
`else
  assign seq_src = entry[11:8];
`endif

  always_ff @(posedge HCLK or negedge HRESETN)
    if (!HRESETN) state <= S_IDLE;
    else          state <= next_state;

  // abort wins over every transition out of the busy states
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (run_rise && !abort) next_state = (n_in == '0) ? S_DONE : S_LOAD;
      S_LOAD:   next_state = abort ? S_IDLE : S_ASSERT;
      S_ASSERT: if (abort) next_state = S_IDLE;
                else if (hold_end) next_state = S_GAP;
      S_GAP:    if (abort) next_state = S_IDLE;
                else if (gap_end) next_state = (last_entry && last_pass) ? S_DONE : S_LOAD;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_LOAD:   busy = 1'b1;
      S_ASSERT: begin busy = 1'b1; start = 1'b1; end
      S_GAP:    busy = 1'b1;
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN)
    if (!HRESETN) begin
      run_q       <= 1'b0;
      cnt         <= '0;
      n_reg       <= '0;
      l_reg       <= '0;
      pass_q      <= '0;
      ptr         <= '0;
      gap_reg     <= '0;
      marker_type <= '0;
      seq_num     <= '0;
      entry_idx   <= '0;
      issued_cnt  <= '0;
      aborted     <= 1'b0;
    end else begin
      run_q   <= run;
      aborted <= abort && busy;
      // one counter times both the start hold and the gap; it restarts on every state change
      if (next_state != state) cnt <= '0;
      else if (cnt != 9'h1FF)  cnt <= cnt + 9'd1;
      if (state == S_IDLE && run_rise && !abort) begin
        n_reg  <= n_in;
        l_reg  <= loop_count;
        ptr    <= '0;
        pass_q <= '0;
      end
      if (issue) begin
        marker_type <= entry[15:12];
        seq_num     <= seq_src;
        gap_reg     <= entry[7:0];
        entry_idx   <= ptr;
        issued_cnt  <= issued_cnt + 32'd1;
      end
      if (state == S_GAP && !abort && gap_end) begin
        if (last_entry) begin
          ptr    <= '0;
          pass_q <= pass_q + 8'd1;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_marker_sequence_scheduler.sv
// Bench for marker_sequence_scheduler: vector table, hand-written corner sequences and randomized runs
// compared against a timeline model built from the table contents.
module tb_marker_sequence_scheduler;
  localparam int DEPTH = 8, START_HOLD = 2, MIN_GAP = 32, AW = 3;

  logic HCLK = 1'b0, HRESETN = 1'b0;
  logic tbl_wr_en = 1'b0;
  logic [AW-1:0] tbl_wr_addr = '0;
  logic [15:0] tbl_wr_data = '0;
  logic [AW:0] num_entries = '0;
  logic [7:0] loop_count = '0;
  logic run = 1'b0, abort = 1'b0;
  logic start, busy, done, aborted;
  logic [3:0] marker_type, seq_num;
  logic [AW-1:0] entry_idx;
  logic [31:0] issued_cnt;

  marker_sequence_scheduler #(.DEPTH(DEPTH), .START_HOLD(START_HOLD), .MIN_GAP(MIN_GAP)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_data(tbl_wr_data), .num_entries(num_entries), .loop_count(loop_count), .run(run),
    .abort(abort), .start(start), .marker_type(marker_type), .seq_num(seq_num), .busy(busy),
    .done(done), .aborted(aborted), .entry_idx(entry_idx), .issued_cnt(issued_cnt));

  always #5 HCLK = ~HCLK;

  typedef struct { int rise; logic [3:0] typ; logic [3:0] seq; int idx; } pulse_t;
  typedef struct { int n; int l; int ak; int ad; int exp_pulses; bit exp_done; } vec_t;

  int checks = 0, failures = 0, cyc = 0;
  logic [15:0] tbl_m [DEPTH];
  int unsigned iss_m = 0;
  logic [3:0] lfsr_m = 4'b0001;
  pulse_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
    cyc++;
  endtask

  task automatic write_entry(input int a, input int t, input int s, input int g);
    tbl_wr_en = 1'b1; tbl_wr_addr = AW'(a); tbl_wr_data = {4'(t), 4'(s), 8'(g)};
    tbl_m[a] = tbl_wr_data;
    tick();
    tbl_wr_en = 1'b0;
  endtask

  // one issued start: bumps the expected count and returns the seq_num the simulator should see
  function automatic logic [3:0] model_issue(input logic [15:0] e);
    logic [3:0] s;
    s = e[11:8];
    iss_m++;
`ifdef MARKER_SCHED_LFSR_EN
    lfsr_m = {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
    if (e[15:12] == 4'd3 || e[15:12] == 4'd11 || e[15:12] == 4'd14) s = lfsr_m;
`endif
    return s;
  endfunction

  // expected pulses for a run raised in cycle t_run; returns the expected done cycle
  function automatic int plan(input int t_run, input int n, input int l, input int limit);
    int nc, t, total;
    nc = (n > DEPTH) ? DEPTH : n;
    t = t_run + 2;
    total = (l == 0) ? limit : nc * l;
    if (limit > 0 && limit < total) total = limit;
    exp_q.delete();
    if (nc == 0) return t_run + 1;
    for (int k = 0; k < total; k++) begin
      pulse_t p;
      int i, g;
      i = k % nc;
      p.rise = t; p.typ = tbl_m[i][15:12]; p.idx = i;
      p.seq = model_issue(tbl_m[i]);
      exp_q.push_back(p);
      g = int'(tbl_m[i][7:0]);
      if (g < MIN_GAP) g = MIN_GAP;
      t = t + START_HOLD + g + 1;
    end
    return t - 1;
  endfunction

  task automatic run_scenario(input string name, input int n, input int l, input int ak,
                              input int ad, input int exp_pulses, input bit exp_done);
    int t_run, done_exp, budget, nrise, width, done_seen, abort_seen, abort_at, dones, aborts, ew;
    logic prev;
    pulse_t got_q[$];
    int width_q[$];
    nrise = 0; width = 0; done_seen = -1; abort_seen = -1; abort_at = -1;
    dones = 0; aborts = 0; prev = 1'b0;
    num_entries = (AW+1)'(n); loop_count = 8'(l);
    t_run = cyc; run = 1'b1;
    done_exp = plan(t_run, n, l, ak);
    if (exp_pulses < 0) exp_pulses = exp_q.size();
    budget = (ak > 0 && exp_q.size() >= ak) ? exp_q[ak-1].rise + ad + 10 : done_exp + 10;
    while (cyc < budget) begin
      tick();
      if (cyc == t_run + 1) run = 1'b0;
      if (start && !prev) begin
        pulse_t p;
        p.rise = cyc; p.typ = marker_type; p.seq = seq_num; p.idx = int'(entry_idx);
        got_q.push_back(p);
        nrise++;
        if (ak > 0 && nrise == ak) abort_at = cyc + ad;
      end
      if (start) width++;
      else if (prev) begin width_q.push_back(width); width = 0; end
      prev = start;
      if (done) begin dones++; done_seen = cyc; end
      if (aborted) begin
        aborts++; abort_seen = cyc;
        check({name, "_start_at_abort"}, int'(start), 0);
      end
      abort = (cyc == abort_at);
      if (done || aborted) break;
    end
    abort = 1'b0;
    tick();
    check({name, "_npulses"}, nrise, exp_pulses);
    for (int i = 0; i < nrise && i < exp_q.size(); i++) begin
      check($sformatf("%s_rise%0d", name, i), got_q[i].rise, exp_q[i].rise);
      check($sformatf("%s_type%0d", name, i), int'(got_q[i].typ), int'(exp_q[i].typ));
      check($sformatf("%s_seq%0d", name, i), int'(got_q[i].seq), int'(exp_q[i].seq));
      check($sformatf("%s_idx%0d", name, i), got_q[i].idx, exp_q[i].idx);
      if (i < width_q.size()) begin
        ew = (ak > 0 && i == ak - 1 && ad < START_HOLD) ? ad + 1 : START_HOLD;
        check($sformatf("%s_width%0d", name, i), width_q[i], ew);
      end
    end
    check({name, "_done_cnt"}, dones, exp_done ? 1 : 0);
    check({name, "_abort_cnt"}, aborts, exp_done ? 0 : 1);
    if (exp_done) check({name, "_done_cycle"}, done_seen, done_exp);
    else          check({name, "_abort_cycle"}, abort_seen, abort_at + 1);
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_pulse_len"}, int'(done) + int'(aborted), 0);
    check({name, "_issued"}, int'(issued_cnt), int'(iss_m));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int rises, dones, bad, n, l, ak, ad, t;
    logic prev;
    vecs[0] = '{3, 1, 0, 0, 3, 1};
    vecs[1] = '{2, 0, 5, 0, 5, 0};
    vecs[2] = '{0, 1, 0, 0, 0, 1};
    vecs[3] = '{3, 2, 0, 0, 6, 1};
    vecs[4] = '{2, 0, 3, 20, 3, 0};
    vecs[5] = '{1, 3, 0, 0, 3, 1};
    vecs[6] = '{12, 1, 0, 0, 8, 1};
    vecs[7] = '{2, 0, 2, 1, 2, 0};

    repeat (3) tick();
    check("rst_start", int'(start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_aborted", int'(aborted), 0);
    check("rst_issued", int'(issued_cnt), 0);
    check("rst_type", int'(marker_type), 0);
    check("rst_seq", int'(seq_num), 0);
    check("rst_idx", int'(entry_idx), 0);
    HRESETN = 1'b1;
    tick();

    write_entry(0, 0, 0, 0);
    write_entry(1, 3, 5, 40);
    write_entry(2, 4, 0, 0);
    for (int a = 3; a < DEPTH; a++)
      write_entry(a, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 70));
    tick();

    for (int v = 0; v < 8; v++) begin
      run_scenario($sformatf("vec%0d", v), vecs[v].n, vecs[v].l, vecs[v].ak, vecs[v].ad,
                   vecs[v].exp_pulses, vecs[v].exp_done);
      tick();
    end

    // abort in IDLE blocks a coincident run edge
    abort = 1'b1; num_entries = 1; loop_count = 1; run = 1'b1; bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 1) abort = 1'b0;
      if (busy || start || aborted || done) bad++;
    end
    run = 1'b0;
    check("idle_abort_activity", bad, 0);
    check("idle_abort_issued", int'(issued_cnt), int'(iss_m));
    tick();

    // run held high: one sequence only; a table write while busy is dropped
    write_entry(0, 5, 7, 0);
    num_entries = 1; loop_count = 1; run = 1'b1; rises = 0; dones = 0; prev = 1'b0;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (start && !prev) rises++;
      prev = start;
      if (done) dones++;
      if (c == 3) begin tbl_wr_en = 1'b1; tbl_wr_addr = '0; tbl_wr_data = 16'h9900; end
      else tbl_wr_en = 1'b0;
    end
    run = 1'b0;
    void'(model_issue(tbl_m[0]));
    check("held_run_pulses", rises, 1);
    check("held_run_dones", dones, 1);
    check("held_run_issued", int'(issued_cnt), int'(iss_m));
    tick();
    run_scenario("after_busy_wr", 1, 1, 0, 0, 1, 1);

    // a new run edge while busy is not queued
    num_entries = 1; loop_count = 1; run = 1'b1; rises = 0; prev = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (c == 0) run = 1'b0;
      if (c == 10) run = 1'b1;
      if (start && !prev) rises++;
      prev = start;
    end
    run = 1'b0;
    void'(model_issue(tbl_m[0]));
    check("busy_edge_pulses", rises, 1);
    check("busy_edge_issued", int'(issued_cnt), int'(iss_m));
    tick();

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++)
        write_entry(a, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 70));
      n = $urandom_range(0, DEPTH + 4);
      if ($urandom_range(0, 2) == 0 && n > 0) begin
        l = 0; ak = $urandom_range(1, 6); ad = $urandom_range(0, 30);
      end else begin
        l = $urandom_range(1, 3); ak = 0; ad = 0;
      end
      run_scenario($sformatf("rnd%0d", r), n, l, ak, ad, -1, ak == 0);
      tick();
    end

    // reset mid-pulse: start drops without waiting for a clock edge
    num_entries = 1; loop_count = 1; run = 1'b1; t = cyc;
    for (int c = 0; c < 10 && !start; c++) begin
      tick();
      if (cyc == t + 1) run = 1'b0;
    end
    check("midrst_start_seen", int'(start), 1);
    #2 HRESETN = 1'b0;
    #1;
    check("midrst_start_async", int'(start), 0);
    check("midrst_busy_async", int'(busy), 0);
    tick();
    check("midrst_issued", int'(issued_cnt), 0);
    check("midrst_type", int'(marker_type), 0);
    HRESETN = 1'b1;
    iss_m = 0; lfsr_m = 4'b0001;
    tick();

    write_entry(0, 11, 6, 0);
    run_scenario("type11_l4", 1, 4, 0, 0, 4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
